uart_boot_loader: RTL and testbench

Sequencer that sits behind the 8N1 UART receiver and turns its byte stream into 32-bit word writes to instruction memory. It keeps the receiver enabled, parses a framed load packet, writes words from address 0 upward, checks a checksum, and holds the MIPS core in reset until a load completes cleanly. It sits between the UART receiver's byte output and the instruction memory write port, alongside the core's reset logic.

---
 rtl/uart_boot_loader_pkg.sv | 7 +
 rtl/uart_boot_loader_timeout.sv | 21 ++
 rtl/uart_boot_loader.sv | 109 ++++++++++
 tb/tb_uart_boot_loader.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_boot_loader_pkg.sv
// uart_boot_loader_pkg: shared FSM encoding and packet constants for the boot loader
package uart_boot_loader_pkg;
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR} state_t;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;
    localparam int LEN_WIDTH = 16;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/uart_boot_loader_timeout.sv
// loader_timeout: inter-byte watchdog that runs only while a packet is in flight
module loader_timeout
    import uart_boot_loader_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 20000
) (
    input  logic   clk,
    input  logic   reset,
    input  state_t state,
    input  logic   rx_valid,
    output logic   expired
);
    localparam int W = $clog2(TIMEOUT_CLKS + 1);
    logic [W-1:0] count;
    logic         enable;
    assign enable = state inside {LEN_HI, LEN_LO, DATA, CHECK};
    assign expired = enable && count == W'(TIMEOUT_CLKS);
    // Count idle cycles; any received byte or leaving the packet states restarts the count
    always_ff @(posedge clk)
        count <= (reset || !enable || rx_valid) ? '0 : count + W'(1);
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: parses framed load packets from the UART and writes words into instruction memory
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH   = 10,
    parameter int         TIMEOUT_CLKS = 20000,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_enable,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);
    localparam logic [LEN_WIDTH:0] CAP = (LEN_WIDTH + 1)'(2 ** ADDR_WIDTH);
    state_t                 state, next;
    logic [7:0]             len_hi, sum;
    logic [LEN_WIDTH-1:0]   len;
    logic [ADDR_WIDTH:0]    word_cnt;
    logic [1:0]             byte_cnt;
    logic [23:0]            assembly;
    logic [LEN_WIDTH:0]     n_rx;
    logic                   sync, expired, last_byte, last_word;

    assign sync = rx_valid && rx_data == SYNC_BYTE;
    assign n_rx = {1'b0, len_hi, rx_data};
    assign last_byte = byte_cnt == 2'(BYTES_PER_WORD - 1);
    assign last_word = (LEN_WIDTH + 1)'(word_cnt) + (LEN_WIDTH + 1)'(1) == {1'b0, len};

    loader_timeout #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timeout (
        .clk(clk),
        .reset(reset),
        .state(state),
        .rx_valid(rx_valid),
        .expired(expired)
    );

    // State register; reset aborts any packet in progress
    always_ff @(posedge clk)
        state <= reset ? IDLE : next;

    // Next state: a byte in the same cycle as timeout expiry wins over the timeout
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = sync ? LEN_HI : IDLE;
            LEN_HI:  next = rx_valid ? LEN_LO : expired ? ERROR : LEN_HI;
            LEN_LO:  next = !rx_valid ? (expired ? ERROR : LEN_LO) :
                            n_rx > CAP ? ERROR : n_rx == '0 ? CHECK : DATA;
            DATA:    next = rx_valid ? (last_byte && last_word ? CHECK : DATA) :
                            expired ? ERROR : DATA;
            CHECK:   next = rx_valid ? (rx_data == sum ? DONE : ERROR) :
                            expired ? ERROR : CHECK;
            default: next = sync ? LEN_HI : state;
        endcase
    end

    // Outputs: the core is released only in DONE, and re-held the moment a restart sync arrives
    always_comb begin
        rx_enable = !reset;
        cpu_hold = reset || state != DONE || sync;
        done = !reset && state == DONE;
        error = !reset && state == ERROR;
    end

    // Datapath: length capture, word assembly, checksum and registered memory write
    always_ff @(posedge clk) begin
        if (reset) begin
            len_hi <= '0;
            len <= '0;
            sum <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            assembly <= '0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (state inside {IDLE, DONE, ERROR} && sync) begin
                sum <= '0;
                word_cnt <= '0;
                byte_cnt <= '0;
                assembly <= '0;
            end
            if (state == LEN_HI && rx_valid)
                len_hi <= rx_data;
            if (state == LEN_LO && rx_valid)
                len <= {len_hi, rx_data};
            if (state == DATA && rx_valid) begin
                sum <= sum + rx_data;
                byte_cnt <= byte_cnt + 2'd1;
                assembly <= {assembly[15:0], rx_data};
                if (last_byte) begin
                    mem_we <= 1'b1;
                    mem_addr <= word_cnt[ADDR_WIDTH-1:0];
                    mem_wdata <= {assembly, rx_data};
                    word_cnt <= word_cnt + (ADDR_WIDTH + 1)'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: scoreboard bench driving directed load packets into uart_boot_loader
module tb_uart_boot_loader;
    localparam int AW = 10;
    localparam int TO = 200;
    localparam int GAP = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_enable, mem_we, cpu_hold, done, error;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    int             total = 0;
    int             bad = 0;
    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] e;
    logic [7:0]     pkt[$];
    logic           prev_we = 1'b0;

    uart_boot_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CLKS(TO)) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_enable(rx_enable),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the next expected word and last exactly one cycle
    always @(negedge clk) begin
        if (!reset && mem_we) begin
            chk("we_width", {31'b0, prev_we}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {22'b0, mem_addr}, {22'b0, e[AW+31:32]});
                chk("wr_data", mem_wdata, e[31:0]);
            end
        end
        prev_we = mem_we;
    end

    task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (GAP) @(posedge clk);
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) send(pkt[i]);
    endtask

    task automatic status(input string name, input logic d, input logic er, input logic h);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({name, "_done"}, {31'b0, done}, {31'b0, d});
        chk({name, "_error"}, {31'b0, error}, {31'b0, er});
        chk({name, "_hold"}, {31'b0, cpu_hold}, {31'b0, h});
        chk({name, "_pending"}, exp_q.size(), 32'd0);
    endtask

    task automatic reset_vals(input string name);
        chk({name, "_rx_enable"}, {31'b0, rx_enable}, 32'd0);
        chk({name, "_mem_we"}, {31'b0, mem_we}, 32'd0);
        chk({name, "_mem_addr"}, {22'b0, mem_addr}, 32'd0);
        chk({name, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({name, "_hold"}, {31'b0, cpu_hold}, 32'd1);
        chk({name, "_done"}, {31'b0, done}, 32'd0);
        chk({name, "_error"}, {31'b0, error}, 32'd0);
    endtask

    task automatic do_reset(input string name);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_vals(name);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_vals("por");
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rx_enable_run", {31'b0, rx_enable}, 32'd1);

        expect_wr(0, 32'h01020304);
        expect_wr(1, 32'hAABBCCDD);
        pkt = {8'h55, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h18};
        send_pkt();
        status("good", 1'b1, 1'b0, 1'b0);

        expect_wr(0, 32'h01020304);
        expect_wr(1, 32'hAABBCCDD);
        pkt = {8'h55, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h19};
        send_pkt();
        status("badsum", 1'b0, 1'b1, 1'b1);

        pkt = {8'h55, 8'h00, 8'h00, 8'h00};
        send_pkt();
        status("empty", 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 rx_data = 8'h55;
        rx_valid = 1'b1;
        @(negedge clk);
        chk("restart_hold", {31'b0, cpu_hold}, 32'd1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (GAP) @(posedge clk);
        pkt = {8'h00, 8'h00, 8'h01};
        send_pkt();
        status("empty_bad", 1'b0, 1'b1, 1'b1);

        do_reset("rst_idle");
        pkt = {8'h12, 8'h34};
        send_pkt();
        status("idle_junk", 1'b0, 1'b0, 1'b1);
        pkt = {8'h55, 8'h04, 8'h01};
        send_pkt();
        status("overflow", 1'b0, 1'b1, 1'b1);
        pkt = {8'h55, 8'h04, 8'h00};
        send_pkt();
        status("max_len", 1'b0, 1'b0, 1'b1);
        do_reset("rst_max");

        pkt = {8'h55, 8'h00, 8'h01, 8'h01, 8'h02};
        send_pkt();
        repeat (TO + 10) @(posedge clk);
        status("timeout", 1'b0, 1'b1, 1'b1);
        expect_wr(0, 32'hDEADBEEF);
        pkt = {8'h55, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};
        send_pkt();
        status("after_to", 1'b1, 1'b0, 1'b0);

        pkt = {8'h55, 8'h00, 8'h02, 8'h01, 8'h02};
        send_pkt();
        do_reset("rst_mid");
        expect_wr(0, 32'h01020304);
        expect_wr(1, 32'hAABBCCDD);
        pkt = {8'h55, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h18};
        send_pkt();
        status("reload", 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
